// File: rtl/imem_loader_pkg.sv
// imem_pkg: definitions shared by the instruction-memory loader and the
// fetch-side byte-lane memories.
//   imem_ld_state_t : loader FSM state encoding
//   IMEM_LANES      : number of byte lanes per instruction word
//   IMEM_LANE_W     : width of a lane index
//   IMEM_ADDR_W     : default word-address width, so loader and memories agree
//   csum_update     : running XOR checksum step
//   lane_onehot     : lane index to one-hot lane write enable
package imem_pkg;

    localparam int IMEM_LANES  = 4;
    localparam int IMEM_LANE_W = $clog2(IMEM_LANES);
    localparam int IMEM_ADDR_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LEN  = 3'd1,
        ST_DATA = 3'd2,
        ST_CSUM = 3'd3,
        ST_DONE = 3'd4,
        ST_ERR  = 3'd5
    } imem_ld_state_t;

    // Fold one payload byte into the running XOR checksum.
    function automatic logic [7:0] csum_update(input logic [7:0] acc, input logic [7:0] data);
        return acc ^ data;
    endfunction

    // One-hot write enable for the given byte lane.
    function automatic logic [IMEM_LANES-1:0] lane_onehot(input logic [IMEM_LANE_W-1:0] lane);
        return {{(IMEM_LANES-1){1'b0}}, 1'b1} << lane;
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream handshake plus byte-lane memory write port.
//   in_valid / in_data / in_ready : valid/ready byte stream into the loader
//   mem_we / mem_addr / mem_wdata : per-lane write enable, shared word
//                                   address and shared write byte
// Modports:
//   slave  : the loader (consumes the stream, drives the memory write port)
//   master : the stream source / memory side
interface imem_loader_if
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) ();

    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic [IMEM_LANES-1:0] mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [7:0]            mem_wdata;

    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the four byte-lane instruction memories.
// Consumes a stream of: header H (word count H+1), (H+1)*4 little-endian
// payload bytes, then one XOR checksum byte over the payload. Each payload
// byte is written to lane lane_cnt at word word_cnt one cycle after accept.
// The core is held in reset until the image has loaded and verified.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : single-cycle load request (honoured in IDLE, DONE, ERR)
//   bus        : stream handshake + memory write port (slave modport)
//   cpu_hold   : 1 keeps the core in reset; 0 only in DONE
//   done       : image loaded and checksum matched (sticky level)
//   error      : checksum mismatch (sticky level)
module imem_loader
    import imem_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);

    imem_ld_state_t        state_r;
    imem_ld_state_t        state_s;

    logic [IMEM_LANE_W-1:0] lane_cnt_r;
    logic [ADDR_W-1:0]      word_cnt_r;
    logic [ADDR_W-1:0]      hdr_r;
    logic [7:0]             csum_r;

    logic                   accept_s;
    logic                   clear_s;
    logic                   last_byte_s;

    logic                   in_ready_r;
    logic [IMEM_LANES-1:0]  mem_we_r;
    logic [ADDR_W-1:0]      mem_addr_r;
    logic [7:0]             mem_wdata_r;
    logic                   cpu_hold_r;
    logic                   done_r;
    logic                   error_r;

    // Handshake qualifier and end-of-payload detect.
    // in_ready_r is high exactly in LEN/DATA/CSUM, so it also gates accepts.
    always_comb begin
        accept_s    = bus.in_valid && in_ready_r;
        last_byte_s = (lane_cnt_r == IMEM_LANE_W'(IMEM_LANES - 1)) && (word_cnt_r == hdr_r);
    end

    // Next-state logic; clear_s resets the counters whenever a fresh load can begin.
    always_comb begin
        state_s = state_r;
        clear_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clear_s = 1'b1;
                if (start) begin
                    state_s = ST_LEN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LEN: begin
                if (accept_s) begin
                    state_s = ST_DATA;
                end else begin
                    state_s = ST_LEN;
                end
            end
            ST_DATA: begin
                if (accept_s && last_byte_s) begin
                    state_s = ST_CSUM;
                end else begin
                    state_s = ST_DATA;
                end
            end
            ST_CSUM: begin
                if (accept_s) begin
                    if (bus.in_data == csum_r) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_ERR;
                    end
                end else begin
                    state_s = ST_CSUM;
                end
            end
            ST_DONE, ST_ERR: begin
                if (start) begin
                    clear_s = 1'b1;
                    state_s = ST_LEN;
                end else begin
                    state_s = state_r;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Header latch, lane/word counters and running checksum.
    // The word counter may wrap after the final word, but DATA is left on that
    // same accept so the wrapped value is never used as a write address.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane_cnt_r <= {IMEM_LANE_W{1'b0}};
            word_cnt_r <= {ADDR_W{1'b0}};
            hdr_r      <= {ADDR_W{1'b0}};
            csum_r     <= 8'h00;
        end else if (clear_s) begin
            lane_cnt_r <= {IMEM_LANE_W{1'b0}};
            word_cnt_r <= {ADDR_W{1'b0}};
            hdr_r      <= {ADDR_W{1'b0}};
            csum_r     <= 8'h00;
        end else if ((state_r == ST_LEN) && accept_s) begin
            hdr_r <= ADDR_W'(bus.in_data);
        end else if ((state_r == ST_DATA) && accept_s) begin
            lane_cnt_r <= lane_cnt_r + IMEM_LANE_W'(1);
            if (lane_cnt_r == IMEM_LANE_W'(IMEM_LANES - 1)) begin
                word_cnt_r <= word_cnt_r + ADDR_W'(1);
            end else begin
                word_cnt_r <= word_cnt_r;
            end
            csum_r <= csum_update(csum_r, bus.in_data);
        end else begin
            hdr_r <= hdr_r;
        end
    end

    // Registered memory write port: one single-lane write per accepted payload byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_we_r    <= {IMEM_LANES{1'b0}};
            mem_addr_r  <= {ADDR_W{1'b0}};
            mem_wdata_r <= 8'h00;
        end else if ((state_r == ST_DATA) && accept_s) begin
            mem_we_r    <= lane_onehot(lane_cnt_r);
            mem_addr_r  <= word_cnt_r;
            mem_wdata_r <= bus.in_data;
        end else begin
            mem_we_r    <= {IMEM_LANES{1'b0}};
        end
    end

    // Status outputs registered from the next state so they track the FSM
    // without an extra cycle of latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            cpu_hold_r <= 1'b1;
            done_r     <= 1'b0;
            error_r    <= 1'b0;
        end else begin
            in_ready_r <= (state_s == ST_LEN) || (state_s == ST_DATA) || (state_s == ST_CSUM);
            cpu_hold_r <= (state_s != ST_DONE);
            done_r     <= (state_s == ST_DONE);
            error_r    <= (state_s == ST_ERR);
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign cpu_hold      = cpu_hold_r;
    assign done          = done_r;
    assign error         = error_r;

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: loads images built by a byte-list reference
// model, and a monitor process checks every memory write against the
// expected write queue filled when each load is issued.
module tb_imem_loader;
    import imem_pkg::*;

    localparam int AW = 8;

    typedef struct packed {
        logic [IMEM_LANES-1:0] we;
        logic [AW-1:0]         addr;
        logic [7:0]            data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic cpu_hold, done, error;

    imem_loader_if #(.ADDR_W(AW)) bus ();

    imem_loader #(.ADDR_W(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .bus      (bus.slave),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    wr_t         exp_q[$];
    logic [7:0]  stream_q[$];
    logic [31:0] words_q[$];
    logic [7:0]  img [IMEM_LANES][256];
    int          addr0_writes = 0;
    wr_t         last_wr = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: stream = header, little-endian payload, XOR checksum.
    // Payload byte i lands in lane i%4 at word i/4. Only the first n_expect
    // payload writes are queued (for loads cut short by reset).
    task automatic build_load(input int h, input logic [7:0] csum_mask, input int n_expect);
        logic [7:0] x;
        logic [7:0] b;
        wr_t        w;
        x = 8'h00;
        stream_q.delete();
        stream_q.push_back(8'(h));
        for (int i = 0; i < (h + 1) * 4; i++) begin
            b = 8'(words_q[i / 4] >> (8 * (i % 4)));
            stream_q.push_back(b);
            x = x ^ b;
            if (i < n_expect) begin
                w.we   = IMEM_LANES'(1 << (i % 4));
                w.addr = AW'(i / 4);
                w.data = b;
                exp_q.push_back(w);
            end
        end
        stream_q.push_back(x ^ csum_mask);
    endtask

    task automatic random_words(input int n);
        words_q.delete();
        for (int i = 0; i < n; i++) words_q.push_back($urandom);
    endtask

    task automatic do_start(input string name);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_ready"}, 32'(bus.in_ready), 32'd1);
        check({name, "_hold"}, 32'(cpu_hold), 32'd1);
        check({name, "_flags"}, {30'd0, done, error}, 32'd0);
    endtask

    // Present stream_q[0..count-1]; gap_pct = chance of in_valid low per cycle,
    // start_pct = chance of a stray start pulse per cycle.
    task automatic drive(input int gap_pct, input int count, input int start_pct);
        bit acc;
        int budget;
        for (int i = 0; i < count; i++) begin
            acc = 1'b0;
            budget = 0;
            while (!acc) begin
                bus.in_valid = ($urandom_range(99) >= gap_pct);
                bus.in_data  = bus.in_valid ? stream_q[i] : 8'($urandom);
                start        = ($urandom_range(99) < start_pct);
                acc          = bus.in_valid && bus.in_ready;
                @(posedge clk); #1;
                budget++;
                if (!acc && budget > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL accept_timeout: byte %0d not accepted, got ready=%0b expected 1", i, bus.in_ready);
                    bus.in_valid = 1'b0;
                    start = 1'b0;
                    return;
                end
            end
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
    endtask

    task automatic check_end(input string name, input bit exp_done);
        check({name, "_done"}, 32'(done), 32'(exp_done));
        check({name, "_error"}, 32'(error), 32'(!exp_done));
        check({name, "_hold"}, 32'(cpu_hold), 32'(!exp_done));
        check({name, "_ready"}, 32'(bus.in_ready), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check({name, "_sticky"}, {30'd0, done, error}, {30'd0, exp_done, !exp_done});
        check({name, "_queue"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every write must follow an accept, keep the core held,
    // and match the next expected write.
    initial begin : monitor
        bit  acc_prev;
        wr_t e;
        acc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.mem_we != '0) begin
                checks++;
                if (!acc_prev) begin
                    errors++;
                    $display("FAIL write_no_accept: got we=%b expected no write", bus.mem_we);
                end
                check("write_hold", 32'(cpu_hold), 32'd1);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got we=%b addr=%0h data=%0h expected none",
                             bus.mem_we, bus.mem_addr, bus.mem_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {12'd0, bus.mem_we, bus.mem_addr, bus.mem_wdata},
                          {12'd0, e.we, e.addr, e.data});
                end
                for (int k = 0; k < IMEM_LANES; k++)
                    if (bus.mem_we[k]) img[k][bus.mem_addr] = bus.mem_wdata;
                if (bus.mem_addr == '0) addr0_writes++;
                last_wr = {bus.mem_we, bus.mem_addr, bus.mem_wdata};
            end
            acc_prev = bus.in_valid && bus.in_ready && rst_n;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_we", 32'(bus.mem_we), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_hold", 32'(cpu_hold), 32'd1);
        check("rst_flags", {30'd0, done, error}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", 32'(bus.in_ready), 32'd0);

        // Single-word image
        words_q.delete();
        words_q.push_back(32'h0000_0013);
        build_load(0, 8'h00, 4);
        do_start("t1");
        drive(0, stream_q.size(), 0);
        check_end("t1", 1'b1);

        // Two-word image
        words_q.delete();
        words_q.push_back(32'h0050_0093);
        words_q.push_back(32'h00A0_0113);
        build_load(1, 8'h00, 8);
        do_start("t2");
        drive(0, stream_q.size(), 0);
        check_end("t2", 1'b1);
        check("t2_b2_a0", 32'(img[2][0]), 32'h50);
        check("t2_b2_a1", 32'(img[2][1]), 32'hA0);

        // Same image with a wrong checksum
        build_load(1, 8'h07, 8);
        do_start("t3");
        drive(0, stream_q.size(), 0);
        check_end("t3", 1'b0);

        // Same image again with ~50% in_valid gaps, restarted from ERR
        build_load(1, 8'h00, 8);
        do_start("t4");
        drive(50, stream_q.size(), 0);
        check_end("t4", 1'b1);

        // Reset after 5 payload bytes, while the 5th write is on the port
        random_words(2);
        build_load(1, 8'h00, 5);
        do_start("t5");
        drive(0, 6, 0);
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("t5_rst_we", 32'(bus.mem_we), 32'd0);
        check("t5_rst_ready", 32'(bus.in_ready), 32'd0);
        check("t5_rst_hold", 32'(cpu_hold), 32'd1);
        check("t5_rst_queue", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        random_words(3);
        build_load(2, 8'h00, 12);
        do_start("t5b");
        drive(25, stream_q.size(), 0);
        check_end("t5b", 1'b1);

        // Full memory with stray start pulses during the load
        random_words(256);
        build_load(255, 8'h00, 1024);
        addr0_writes = 0;
        do_start("t6");
        drive(20, stream_q.size(), 5);
        check_end("t6", 1'b1);
        check("t6_last_wr", {12'd0, last_wr.we, last_wr.addr}, {12'd0, 4'b1000, 8'hFF});
        check("t6_addr0_writes", 32'(addr0_writes), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
